divisor_arbitro_rr: RTL and testbench

//  Shares one pipelined signed divider among N_REQ requesters, one issue per cycle.

---
 rtl/divisor_pkg.sv | 14 +
 rtl/divisor_tag_fifo.sv | 57 +++++
 rtl/divisor_arbitro_rr.sv | 139 +++++++++++++
 tb/tb_divisor_arbitro_rr.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divisor_pkg.sv
// Types and constants shared by the divider arbiter and its tag FIFO.
package divisor_pkg;

  localparam int TAMANYO_DEF = 32;
  localparam int N_REQ_DEF   = 4;
  localparam int TAG_W       = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

  typedef logic [TAMANYO_DEF-1:0] operando_t;
  typedef logic [TAG_W-1:0]       tag_t;

  // Quotient reported for a short-circuited divide by zero
  localparam operando_t COC_DIV_CERO = '1;

endpackage

// File: rtl/divisor_tag_fifo.sv
// In-order FIFO of requester tags, one entry per divide in flight.
// Depth equals the number of requesters. Each requester has at most one
// outstanding divide, so a full FIFO can never be pushed.
module divisor_tag_fifo
  import divisor_pkg::*;
#(
  parameter int DEPTH = N_REQ_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  tag_t tag_i,
  input  logic pop_i,
  output logic empty_o,
  output tag_t head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  tag_t          mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push_i & (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i  & (cnt_q != '0);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Storage has no reset; occupancy is tracked by the pointers
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= tag_i;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= nxt(wr_q);
      if (do_pop)  rd_q <= nxt(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/divisor_arbitro_rr.sv
// Round-robin front end that shares one pipelined signed divider.
// The arbiter accepts one request per cycle and registers the operands
// toward the divider. A tag FIFO records which requester each issued divide
// belongs to, so that each result is returned to its originator.
// Optional feature DIVISOR_CERO_CHECK_EN: when defined, a zero denominator
// is answered locally on the next cycle with rsp_err set and is never issued.
// When undefined, it is issued to the divider and rsp_err stays 0.
// N_REQ must match N_REQ_DEF in divisor_pkg, because tag_t is sized from it.
module divisor_arbitro_rr
  import divisor_pkg::*;
#(
  parameter int tamanyo = TAMANYO_DEF,
  parameter int N_REQ   = N_REQ_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_REQ-1:0]                req_valid_i,
  output logic [N_REQ-1:0]                req_ready_o,
  input  logic [N_REQ-1:0][tamanyo-1:0]   req_num_i,
  input  logic [N_REQ-1:0][tamanyo-1:0]   req_den_i,
  output logic [N_REQ-1:0]                rsp_valid_o,
  output logic [N_REQ-1:0][tamanyo-1:0]   rsp_coc_o,
  output logic [N_REQ-1:0][tamanyo-1:0]   rsp_res_o,
  output logic [N_REQ-1:0]                rsp_err_o,
  output logic                            div_start_o,
  output logic [tamanyo-1:0]              div_num_o,
  output logic [tamanyo-1:0]              div_den_o,
  input  logic                            div_done_i,
  input  logic [tamanyo-1:0]              div_coc_i,
  input  logic [tamanyo-1:0]              div_res_i,
  output logic                            err_orphan_o
);

  logic [N_REQ-1:0]              busy_q;
  tag_t                          last_q;
  logic                          div_start_q;
  logic [tamanyo-1:0]            div_num_q, div_den_q;
  logic [N_REQ-1:0]              rsp_valid_q, rsp_err_q;
  logic [N_REQ-1:0][tamanyo-1:0] rsp_coc_q, rsp_res_q;
  logic                          err_orphan_q;

  logic [N_REQ-1:0] elig, gnt_vec;
  logic             gnt_vld, zero_den, issue, pop;
  tag_t             gnt_idx, cand, head;
  logic             fifo_empty;

  assign elig = req_valid_i & ~busy_q;

  // Scan from the requester after the last grant, wrapping to index 0
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    gnt_vec = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = tag_t'((int'(last_q) + k) % N_REQ);
      if (!gnt_vld && elig[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_vld) gnt_vec[gnt_idx] = 1'b1;
  end

`ifdef DIVISOR_CERO_CHECK_EN
  assign zero_den = gnt_vld && (req_den_i[gnt_idx] == '0);
`else
  assign zero_den = 1'b0;
`endif

  // The grant output is held at zero in reset, when no state may change
  assign req_ready_o = rst_i ? '0 : gnt_vec;
  assign issue       = gnt_vld & ~zero_den & ~rst_i;
  assign pop         = div_done_i & ~fifo_empty;

  divisor_tag_fifo #(.DEPTH(N_REQ)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (issue),
    .tag_i   (gnt_idx),
    .pop_i   (pop),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // Issue register, busy tracking, response demux and orphan flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q       <= '0;
      last_q       <= tag_t'(N_REQ - 1);
      div_start_q  <= 1'b0;
      div_num_q    <= '0;
      div_den_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_coc_q    <= '0;
      rsp_res_q    <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      if (gnt_vld) last_q <= gnt_idx;
      if (issue) begin
        div_start_q     <= 1'b1;
        div_num_q       <= req_num_i[gnt_idx];
        div_den_q       <= req_den_i[gnt_idx];
        busy_q[gnt_idx] <= 1'b1;
      end
      // The head requester is busy, so it can never be the one issuing now
      if (pop) begin
        rsp_valid_q[head] <= 1'b1;
        rsp_coc_q[head]   <= div_coc_i;
        rsp_res_q[head]   <= div_res_i;
        busy_q[head]      <= 1'b0;
      end
`ifdef DIVISOR_CERO_CHECK_EN
      // A zero-divisor requester is not busy, so it never collides with a pop
      if (zero_den) begin
        rsp_valid_q[gnt_idx] <= 1'b1;
        rsp_err_q[gnt_idx]   <= 1'b1;
        rsp_coc_q[gnt_idx]   <= tamanyo'(COC_DIV_CERO);
        rsp_res_q[gnt_idx]   <= req_num_i[gnt_idx];
      end
`endif
      if (div_done_i && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  assign div_start_o  = div_start_q;
  assign div_num_o    = div_num_q;
  assign div_den_o    = div_den_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_coc_o    = rsp_coc_q;
  assign rsp_res_o    = rsp_res_q;
  assign err_orphan_o = err_orphan_q;

endmodule

// File: tb/tb_divisor_arbitro_rr.sv
// Bench for divisor_arbitro_rr: a fixed-latency divider stub, plus a
// reference that predicts grants and results from request timestamps.
module tb_divisor_arbitro_rr;

  localparam int W   = 32;
  localparam int N   = 4;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        req_valid, req_ready, rsp_valid, rsp_err;
  logic [N-1:0][W-1:0] req_num, req_den, rsp_coc, rsp_res;
  logic                div_start, div_done, err_orphan;
  logic [W-1:0]        div_num, div_den, div_coc, div_res;

  divisor_arbitro_rr #(.tamanyo(W), .N_REQ(N)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_num_i(req_num), .req_den_i(req_den),
    .rsp_valid_o(rsp_valid), .rsp_coc_o(rsp_coc), .rsp_res_o(rsp_res), .rsp_err_o(rsp_err),
    .div_start_o(div_start), .div_num_o(div_num), .div_den_o(div_den),
    .div_done_i(div_done), .div_coc_i(div_coc), .div_res_i(div_res),
    .err_orphan_o(err_orphan)
  );

  function automatic logic [W-1:0] ref_q(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
    if (d == 0) return '1;
    return n / d;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic signed [W-1:0] n, input logic signed [W-1:0] d);
    if (d == 0) return n;
    return n % d;
  endfunction

  // Divider stub: LAT-cycle pipeline sharing the reset; frc injects a stray done
  logic [LAT-1:0] dv;
  logic [W-1:0]   dq [LAT];
  logic [W-1:0]   dr [LAT];
  logic           frc = 1'b0;
  logic [W-1:0]   frc_q = '0;

  always @(posedge clk) begin
    if (rst) dv <= '0;
    else     dv <= {dv[LAT-2:0], div_start};
    dq[0] <= ref_q(div_num, div_den);
    dr[0] <= ref_r(div_num, div_den);
    for (int s = 1; s < LAT; s++) begin
      dq[s] <= dq[s-1];
      dr[s] <= dr[s-1];
    end
  end

  assign div_done = dv[LAT-1] | frc;
  assign div_coc  = frc ? frc_q : dq[LAT-1];
  assign div_res  = frc ? ~frc_q : dr[LAT-1];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference state: expected responses carry the cycle they must appear in
  typedef struct {
    int       t;
    int       idx;
    logic [W-1:0] c;
    logic [W-1:0] r;
    bit       e;
  } exp_t;

  exp_t         sbq[$];
  int           cyc = 0;
  bit           known = 0;
  int           last_m;
  int           busy_end [N];
  logic [W-1:0] hold_c [N];
  logic [W-1:0] hold_r [N];
  bit           orphan_m;
  bit           prev_iss;
  logic [W-1:0] prev_n, prev_d;

  // Request sources: each holds its request until the reference sees it granted
  bit           src_v [N];
  logic [W-1:0] src_n [N];
  logic [W-1:0] src_d [N];
  bit           acc [N];
  bit           refill = 0;
  bit           rnd = 0;
  bit           glog_en = 0;
  logic [N-1:0] glog[$];

  task automatic reset_model();
    sbq.delete();
    last_m   = N - 1;
    orphan_m = 0;
    prev_iss = 0;
    for (int i = 0; i < N; i++) begin
      busy_end[i] = 0;
      hold_c[i]   = '0;
      hold_r[i]   = '0;
    end
  endtask

  task automatic gen(input int i);
    logic [W-1:0] n, d;
    n = $urandom;
    if ($urandom_range(0, 3) == 0) n = W'($urandom_range(0, 1000));
    if ($urandom_range(0, 9) == 0) d = '0;
    else begin
      d = W'($urandom_range(1, 200));
      if ($urandom_range(0, 1) == 1) d = -d;
    end
    if (n == 32'h8000_0000 && d == '1) n = '0;
    src_v[i] = 1; src_n[i] = n; src_d[i] = d;
  endtask

  task automatic model_check(input bit r, input bit f);
    logic [N-1:0]        ev, ee, el, eg;
    logic [N-1:0][W-1:0] hc, hr;
    int g, j;
    bit zd;
    ev = '0; ee = '0;
    if (!known) begin
      if (r) begin reset_model(); known = 1; end
      return;
    end
    for (int q = sbq.size() - 1; q >= 0; q--) begin
      if (sbq[q].t == cyc) begin
        ev[sbq[q].idx]     = 1'b1;
        ee[sbq[q].idx]     = sbq[q].e;
        hold_c[sbq[q].idx] = sbq[q].c;
        hold_r[sbq[q].idx] = sbq[q].r;
        sbq.delete(q);
      end
    end
    for (int i = 0; i < N; i++) begin
      hc[i] = hold_c[i];
      hr[i] = hold_r[i];
    end
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_coc", rsp_coc, hc);
    chk("rsp_res", rsp_res, hr);
    chk("div_start", div_start, prev_iss);
    if (prev_iss) begin
      chk("div_num", div_num, prev_n);
      chk("div_den", div_den, prev_d);
    end
    chk("err_orphan", err_orphan, orphan_m);
    if (f) orphan_m = 1;
    if (r) begin
      chk("ready_in_rst", req_ready, '0);
      reset_model();
      return;
    end
    for (int i = 0; i < N; i++) el[i] = req_valid[i] && (cyc >= busy_end[i]);
    g = -1;
    for (int k = 1; k <= N; k++) begin
      j = (last_m + k) % N;
      if (g < 0 && el[j]) g = j;
    end
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("req_ready", req_ready, eg);
    if (glog_en && req_ready != '0) glog.push_back(req_ready);
    prev_iss = 0;
    if (g >= 0) begin
      last_m = g;
      acc[g] = 1;
      zd = 0;
`ifdef DIVISOR_CERO_CHECK_EN
      zd = (src_d[g] == '0);
`endif
      if (zd) sbq.push_back('{cyc + 1, g, '1, src_n[g], 1'b1});
      else begin
        sbq.push_back('{cyc + LAT + 2, g, ref_q(src_n[g], src_d[g]), ref_r(src_n[g], src_d[g]), 1'b0});
        busy_end[g] = cyc + LAT + 2;
        prev_iss = 1;
        prev_n   = src_n[g];
        prev_d   = src_d[g];
      end
    end
  endtask

  // One clock: drive after the edge, check on the falling edge
  task automatic step(input bit r, input bit f);
    @(posedge clk);
    #1;
    cyc++;
    rst   = r;
    frc   = f;
    frc_q = $urandom;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin src_v[i] = 0; acc[i] = 0; end
      if (!src_v[i] && (refill || (rnd && $urandom_range(0, 99) < 40))) gen(i);
      req_valid[i] = src_v[i];
      req_num[i]   = src_n[i];
      req_den[i]   = src_d[i];
    end
    @(negedge clk);
    model_check(r, f);
  endtask

  task automatic drain(input int maxc);
    int  n;
    bit  pend;
    n = 0;
    pend = 1;
    while (pend && n < maxc) begin
      step(0, 0);
      n++;
      pend = (sbq.size() != 0);
      for (int i = 0; i < N; i++) if (src_v[i]) pend = 1;
    end
    chk("drain_timeout", pend, 1'b0);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] n, input logic [W-1:0] d);
    src_v[i] = 1; src_n[i] = n; src_d[i] = d;
  endtask

  initial begin
    logic [N-1:0] g0, g1, g2, g3;
    for (int i = 0; i < N; i++) begin
      src_v[i] = 0; src_n[i] = '0; src_d[i] = '0; acc[i] = 0;
    end
    req_valid = '0; req_num = '0; req_den = '0;

    // Power-on reset
    repeat (3) step(1, 0);

    // All requesters valid continuously: grants 0,1,2,3 then a busy gap
    glog_en = 1; refill = 1;
    repeat (20) step(0, 0);
    refill = 0; glog_en = 0;
    drain(60);
    g0 = (glog.size() > 0) ? glog[0] : '0;
    g1 = (glog.size() > 1) ? glog[1] : '0;
    g2 = (glog.size() > 2) ? glog[2] : '0;
    g3 = (glog.size() > 3) ? glog[3] : '0;
    chk("t3_order", {g3, g2, g1, g0}, 16'h8421);

    // Lone request on requester 2
    set_req(2, 32'd100, 32'd7);
    drain(40);
    chk("t2_coc", rsp_coc[2], 32'd14);
    chk("t2_res", rsp_res[2], 32'd2);

    // Signed operands, issued back-to-back
    set_req(0, -32'sd7, 32'sd2);
    set_req(1, 32'sd7, -32'sd2);
    drain(40);
    chk("t4_coc0", rsp_coc[0], 32'hFFFF_FFFD);
    chk("t4_res0", rsp_res[0], 32'hFFFF_FFFF);
    chk("t4_coc1", rsp_coc[1], 32'hFFFF_FFFD);
    chk("t4_res1", rsp_res[1], 32'd1);

    // Zero divisor on requester 1
    set_req(1, 32'd5, 32'd0);
    drain(40);
    chk("t5_coc", rsp_coc[1], 32'hFFFF_FFFF);
    chk("t5_res", rsp_res[1], 32'd5);

    // Stray done with nothing in flight
    step(0, 1);
    repeat (3) step(0, 0);
    chk("t6_orphan", err_orphan, 1'b1);

    // Random traffic, reset in the middle of it, more traffic
    rnd = 1;
    repeat (300) step(0, 0);
    repeat (3) step(1, 0);
    repeat (300) step(0, 0);
    rnd = 0;
    drain(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
